// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the MiniRiscV stage controller: opcodes, ALUOp codes,
// PC-select codes, FSM states and instruction classes.
package cpu_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [3:0] ALU_LS    = 4'b0000;
   localparam logic [3:0] ALU_BR    = 4'b0001;
   localparam logic [3:0] ALU_R     = 4'b0010;
   localparam logic [3:0] ALU_I     = 4'b0011;
   localparam logic [3:0] ALU_JMP   = 4'b0100;
   localparam logic [3:0] ALU_LUI   = 4'b0101;
   localparam logic [3:0] ALU_AUIPC = 4'b0110;

   localparam logic [1:0] PC_PLUS4 = 2'b00;
   localparam logic [1:0] PC_REL   = 2'b01;
   localparam logic [1:0] PC_JALR  = 2'b10;

   typedef enum logic [2:0] {
      ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT, ST_TRAP
   } state_t;

   typedef enum logic [3:0] {
      CL_NOP, CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH,
      CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_SYSTEM
   } class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: instruction class, ALU controls and
// register-write intent. Unknown opcodes come out as NOP with o_illegal set.
module ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [6:0] i_opcode,
   output class_t     o_cls,
   output logic [3:0] o_alu_op,
   output logic       o_alu_src,
   output logic       o_alu_a_pc,
   output logic       o_reg_write,
   output logic       o_illegal
);

   always_comb begin
      o_cls       = CL_NOP;
      o_alu_op    = ALU_LS;
      o_alu_src   = 1'b0;
      o_alu_a_pc  = 1'b0;
      o_reg_write = 1'b0;
      o_illegal   = 1'b0;
      case (i_opcode)
         OP_R:      begin o_cls = CL_R;      o_alu_op = ALU_R;     o_reg_write = 1'b1; end
         OP_I:      begin o_cls = CL_I;      o_alu_op = ALU_I;     o_alu_src = 1'b1; o_reg_write = 1'b1; end
         OP_LOAD:   begin o_cls = CL_LOAD;   o_alu_op = ALU_LS;    o_alu_src = 1'b1; o_reg_write = 1'b1; end
         OP_STORE:  begin o_cls = CL_STORE;  o_alu_op = ALU_LS;    o_alu_src = 1'b1; end
         OP_BRANCH: begin o_cls = CL_BRANCH; o_alu_op = ALU_BR;    end
         OP_JAL:    begin o_cls = CL_JAL;    o_alu_op = ALU_JMP;   o_alu_a_pc = 1'b1; o_reg_write = 1'b1; end
         OP_JALR:   begin o_cls = CL_JALR;   o_alu_op = ALU_JMP;   o_alu_a_pc = 1'b1; o_reg_write = 1'b1; end
         OP_LUI:    begin o_cls = CL_LUI;    o_alu_op = ALU_LUI;   o_alu_src = 1'b1; o_reg_write = 1'b1; end
         OP_AUIPC:  begin o_cls = CL_AUIPC;  o_alu_op = ALU_AUIPC; o_alu_src = 1'b1; o_alu_a_pc = 1'b1; o_reg_write = 1'b1; end
         OP_SYSTEM: o_cls = CL_SYSTEM;
         default:   o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/cpu_stage_controller.sv
// Multi-cycle stage sequencer for MiniRiscV: memory handshakes, ALU control
// hold from DECODE to WB, PC/writeback strobes and the instret counter.
//   state  | meaning
//   FETCH  | imem request until ack; IR latched on the ack cycle
//   DECODE | classify opcode, drive ALU controls
//   EXEC   | ALU computes; branch condition captured
//   MEM    | data request held until ack
//   WB     | commit: PC update, register write, retire
//   HALT   | ecall/ebreak retired on entry, idle until reset
//   TRAP   | illegal opcode, idle until reset
module cpu_stage_controller
   import cpu_ctrl_pkg::*;
#(
   parameter bit TRAP_ON_ILLEGAL = 1'b1,
   parameter int CNT_W           = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       i_opcode,
   input  logic             i_imem_ready,
   input  logic             i_dmem_ready,
   input  logic             i_do_branch,
   output logic             o_ir_write,
   output logic             o_imem_req,
   output logic             o_dmem_req,
   output logic             o_dmem_we,
   output logic [3:0]       o_alu_op,
   output logic             o_alu_src,
   output logic             o_alu_a_pc,
   output logic             o_reg_write,
   output logic             o_wb_sel,
   output logic             o_pc_write,
   output logic [1:0]       o_pc_sel,
   output logic             o_retired,
   output logic [CNT_W-1:0] o_instret,
   output logic             o_halted,
   output logic             o_illegal
);

   state_t           r_state, w_next;
   class_t           w_dec_cls, r_cls;
   logic [3:0]       w_dec_alu_op, r_alu_op;
   logic             w_dec_alu_src, w_dec_alu_a_pc, w_dec_reg_write, w_dec_illegal;
   logic             r_alu_src, r_alu_a_pc, r_reg_write;
   logic             r_branch_taken, r_halted, r_illegal, r_halt_entry;
   logic [CNT_W-1:0] r_instret;
   logic             w_hold, w_enter_halt, w_enter_trap;

   ctrl_decode u_decode (
      .i_opcode    (i_opcode),
      .o_cls       (w_dec_cls),
      .o_alu_op    (w_dec_alu_op),
      .o_alu_src   (w_dec_alu_src),
      .o_alu_a_pc  (w_dec_alu_a_pc),
      .o_reg_write (w_dec_reg_write),
      .o_illegal   (w_dec_illegal)
   );

   assign w_hold       = (r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB);
   assign w_enter_halt = (r_state == ST_DECODE) && (w_next == ST_HALT);
   assign w_enter_trap = (r_state == ST_DECODE) && (w_next == ST_TRAP);

   always_ff @(posedge clk) begin
      if (!rst) r_state <= ST_FETCH;
      else      r_state <= w_next;
   end

   // Outputs are forced quiet while rst is low so a dropped handshake never commits.
   always_comb begin
      w_next      = r_state;
      o_ir_write  = 1'b0;
      o_imem_req  = 1'b0;
      o_dmem_req  = 1'b0;
      o_dmem_we   = 1'b0;
      o_alu_op    = ALU_LS;
      o_alu_src   = 1'b0;
      o_alu_a_pc  = 1'b0;
      o_reg_write = 1'b0;
      o_wb_sel    = 1'b0;
      o_pc_write  = 1'b0;
      o_pc_sel    = PC_PLUS4;
      o_retired   = 1'b0;
      if (!rst) begin
         w_next = ST_FETCH;
      end else begin
         if (w_hold) begin
            o_alu_op   = r_alu_op;
            o_alu_src  = r_alu_src;
            o_alu_a_pc = r_alu_a_pc;
         end
         case (r_state)
            ST_FETCH: begin
               o_imem_req = 1'b1;
               if (i_imem_ready) begin
                  o_ir_write = 1'b1;
                  w_next     = ST_DECODE;
               end
            end
            ST_DECODE: begin
               o_alu_op   = w_dec_alu_op;
               o_alu_src  = w_dec_alu_src;
               o_alu_a_pc = w_dec_alu_a_pc;
               if (w_dec_cls == CL_SYSTEM) w_next = ST_HALT;
               else if (w_dec_illegal)     w_next = TRAP_ON_ILLEGAL ? ST_TRAP : ST_WB;
               else                        w_next = ST_EXEC;
            end
            ST_EXEC: begin
               w_next = ((r_cls == CL_LOAD) || (r_cls == CL_STORE)) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
               o_dmem_req = 1'b1;
               o_dmem_we  = (r_cls == CL_STORE);
               if (i_dmem_ready) w_next = ST_WB;
            end
            ST_WB: begin
               o_pc_write  = 1'b1;
               o_retired   = 1'b1;
               o_reg_write = r_reg_write;
               o_wb_sel    = (r_cls == CL_LOAD);
               if (r_cls == CL_JALR)
                  o_pc_sel = PC_JALR;
               else if ((r_cls == CL_JAL) || ((r_cls == CL_BRANCH) && r_branch_taken))
                  o_pc_sel = PC_REL;
               w_next = ST_FETCH;
            end
            ST_HALT: begin
               o_pc_write = r_halt_entry;
               o_retired  = r_halt_entry;
            end
            ST_TRAP: w_next = ST_TRAP;
            default: w_next = ST_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cls          <= CL_NOP;
         r_alu_op       <= ALU_LS;
         r_alu_src      <= 1'b0;
         r_alu_a_pc     <= 1'b0;
         r_reg_write    <= 1'b0;
         r_branch_taken <= 1'b0;
         r_halted       <= 1'b0;
         r_illegal      <= 1'b0;
         r_halt_entry   <= 1'b0;
         r_instret      <= '0;
      end else begin
         if (r_state == ST_DECODE) begin
            r_cls       <= w_dec_cls;
            r_alu_op    <= w_dec_alu_op;
            r_alu_src   <= w_dec_alu_src;
            r_alu_a_pc  <= w_dec_alu_a_pc;
            r_reg_write <= w_dec_reg_write;
         end
         if (r_state == ST_EXEC) r_branch_taken <= i_do_branch;
         if (w_enter_halt)       r_halted       <= 1'b1;
         if (w_enter_trap)       r_illegal      <= 1'b1;
         r_halt_entry <= w_enter_halt;
         if (o_retired) r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_instret = r_instret;
   assign o_halted  = r_halted;
   assign o_illegal = r_illegal;

endmodule

// File: tb/tb_cpu_stage_controller.sv
// Bench for cpu_stage_controller: two instances (trap / NOP-on-illegal with a
// 4-bit counter) driven in lockstep, checked every cycle against a class-level model.
module tb_cpu_stage_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] opcode = '0;
   logic       imem_ready = 1'b0, dmem_ready = 1'b0, do_branch = 1'b0;

   logic        a_irw, a_imr, a_dmr, a_dwe, a_src, a_apc, a_rw, a_wbs, a_pcw, a_ret, a_hlt, a_ill;
   logic [3:0]  a_aop;
   logic [1:0]  a_pcs;
   logic [31:0] a_cnt;
   logic        b_irw, b_imr, b_dmr, b_dwe, b_src, b_apc, b_rw, b_wbs, b_pcw, b_ret, b_hlt, b_ill;
   logic [3:0]  b_aop;
   logic [1:0]  b_pcs;
   logic [3:0]  b_cnt;
   logic [17:0] a_vec, b_vec;

   assign a_vec = {a_irw, a_imr, a_dmr, a_dwe, a_aop, a_src, a_apc, a_rw, a_wbs, a_pcw, a_pcs, a_ret, a_hlt, a_ill};
   assign b_vec = {b_irw, b_imr, b_dmr, b_dwe, b_aop, b_src, b_apc, b_rw, b_wbs, b_pcw, b_pcs, b_ret, b_hlt, b_ill};

   cpu_stage_controller #(.TRAP_ON_ILLEGAL(1'b1), .CNT_W(32)) dut_a (
      .clk(clk), .rst(rst), .i_opcode(opcode), .i_imem_ready(imem_ready),
      .i_dmem_ready(dmem_ready), .i_do_branch(do_branch),
      .o_ir_write(a_irw), .o_imem_req(a_imr), .o_dmem_req(a_dmr), .o_dmem_we(a_dwe),
      .o_alu_op(a_aop), .o_alu_src(a_src), .o_alu_a_pc(a_apc), .o_reg_write(a_rw),
      .o_wb_sel(a_wbs), .o_pc_write(a_pcw), .o_pc_sel(a_pcs), .o_retired(a_ret),
      .o_instret(a_cnt), .o_halted(a_hlt), .o_illegal(a_ill));

   cpu_stage_controller #(.TRAP_ON_ILLEGAL(1'b0), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .i_opcode(opcode), .i_imem_ready(imem_ready),
      .i_dmem_ready(dmem_ready), .i_do_branch(do_branch),
      .o_ir_write(b_irw), .o_imem_req(b_imr), .o_dmem_req(b_dmr), .o_dmem_we(b_dwe),
      .o_alu_op(b_aop), .o_alu_src(b_src), .o_alu_a_pc(b_apc), .o_reg_write(b_rw),
      .o_wb_sel(b_wbs), .o_pc_write(b_pcw), .o_pc_sel(b_pcs), .o_retired(b_ret),
      .o_instret(b_cnt), .o_halted(b_hlt), .o_illegal(b_ill));

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] op;
      logic       br;
      int         iw;
      int         dw;
      logic [3:0] aop;
      logic       src;
      logic       apc;
      logic       rw;
      logic       wbs;
      logic [1:0] pcs;
      logic       mem;
      logic       st;
   } vec_t;

   vec_t tbl[10];
   int   errors = 0;
   int   checks = 0;
   int   cnt_a  = 0;
   int   cnt_b  = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, exp);
      end
   endtask

   function automatic logic [17:0] ev(input logic irw, imr, dmr, dwe, input logic [3:0] aop,
                                      input logic src, apc, rw, wbs, pcw, input logic [1:0] pcs,
                                      input logic ret, hlt, ill);
      return {irw, imr, dmr, dwe, aop, src, apc, rw, wbs, pcw, pcs, ret, hlt, ill};
   endfunction

   task automatic rnd_in();
      imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom);
      do_branch  = 1'($urandom);
   endtask

   // inputs already driven for this cycle; compare away from the edge, then advance
   task automatic cyc(input string nm, input logic [17:0] ea, input logic [17:0] eb);
      @(negedge clk);
      chk({nm, "_A"}, 32'(a_vec), 32'(ea));
      chk({nm, "_B"}, 32'(b_vec), 32'(eb));
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cnt(input string nm);
      chk({nm, "_instret_A"}, a_cnt, 32'(cnt_a));
      chk({nm, "_instret_B"}, 32'(b_cnt), 32'(cnt_b % 16));
   endtask

   task automatic do_reset();
      rst = 1'b0;
      rnd_in();
      imem_ready = 1'b1;
      @(posedge clk);
      #1;
      cyc("in_reset", 18'h0, 18'h0);
      rst   = 1'b1;
      cnt_a = 0;
      cnt_b = 0;
   endtask

   task automatic fetch(input int iw);
      logic [17:0] e;
      for (int k = 0; k <= iw; k++) begin
         rnd_in();
         opcode     = 7'($urandom);
         imem_ready = (k == iw);
         e = ev(k == iw, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
         cyc("fetch", e, e);
      end
   endtask

   task automatic run_instr(input vec_t v);
      logic [17:0] e;
      chk_cnt("start");
      fetch(v.iw);
      rnd_in();
      opcode = v.op;
      e = ev(1'b0, 1'b0, 1'b0, 1'b0, v.aop, v.src, v.apc, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      cyc("decode", e, e);
      rnd_in();
      do_branch = v.br;
      cyc("exec", e, e);
      if (v.mem) begin
         for (int k = 0; k <= v.dw; k++) begin
            rnd_in();
            dmem_ready = (k == v.dw);
            e = ev(1'b0, 1'b0, 1'b1, v.st, v.aop, v.src, v.apc, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
            cyc("mem", e, e);
         end
      end
      rnd_in();
      e = ev(1'b0, 1'b0, 1'b0, 1'b0, v.aop, v.src, v.apc, v.rw, v.wbs, 1'b1, v.pcs, 1'b1, 1'b0, 1'b0);
      cyc("wb", e, e);
      cnt_a++;
      cnt_b++;
   endtask

   task automatic run_halt(input int iw);
      logic [17:0] e;
      chk_cnt("halt_start");
      fetch(iw);
      rnd_in();
      opcode = 7'b1110011;
      cyc("halt_decode", 18'h0, 18'h0);
      rnd_in();
      e = ev(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
      cyc("halt_entry", e, e);
      cnt_a++;
      cnt_b++;
      e = ev(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         rnd_in();
         imem_ready = 1'b1;
         opcode     = 7'($urandom);
         cyc("halted", e, e);
      end
      chk_cnt("halt_end");
   endtask

   // dut_a traps; dut_b retires the same opcode as a NOP and goes back to FETCH
   task automatic run_illegal(input int iw);
      logic [17:0] ea, eb;
      chk_cnt("ill_start");
      fetch(iw);
      rnd_in();
      opcode = 7'b1111111;
      cyc("ill_decode", 18'h0, 18'h0);
      rnd_in();
      imem_ready = 1'b0;
      ea = ev(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
      eb = ev(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
      cyc("ill_wb", ea, eb);
      cnt_b++;
      eb = ev(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         rnd_in();
         imem_ready = 1'b0;
         cyc("ill_after", ea, eb);
      end
      chk_cnt("ill_end");
   endtask

   function automatic vec_t rand_vec();
      vec_t v;
      v    = tbl[$urandom_range(0, 9)];
      v.iw = $urandom_range(0, 3);
      v.dw = $urandom_range(0, 3);
      v.br = 1'($urandom);
      if (v.op == 7'b1100011) v.pcs = v.br ? 2'b01 : 2'b00;
      return v;
   endfunction

   initial begin
      //            op          br    iw dw aop      src   apc   rw    wbs   pcs    mem   st
      tbl[0] = '{7'b0010011, 1'b0, 0, 0, 4'b0011, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
      tbl[1] = '{7'b0000011, 1'b0, 0, 2, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0};
      tbl[2] = '{7'b1100011, 1'b1, 1, 0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
      tbl[3] = '{7'b1100011, 1'b0, 0, 0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
      tbl[4] = '{7'b1100111, 1'b1, 0, 0, 4'b0100, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0};
      tbl[5] = '{7'b0110011, 1'b1, 2, 0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
      tbl[6] = '{7'b0100011, 1'b0, 0, 1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1};
      tbl[7] = '{7'b1101111, 1'b0, 0, 0, 4'b0100, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0};
      tbl[8] = '{7'b0110111, 1'b1, 0, 0, 4'b0101, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
      tbl[9] = '{7'b0010111, 1'b0, 1, 0, 4'b0110, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};

      do_reset();
      for (int i = 0; i < 10; i++) run_instr(tbl[i]);

      run_illegal(1);
      do_reset();

      // long reset-free stretch so the 4-bit counter of dut_b wraps
      for (int i = 0; i < 40; i++) run_instr(rand_vec());

      // reset in the middle of a store handshake, then ebreak
      begin
         logic [17:0] e;
         chk_cnt("sw_start");
         fetch(0);
         rnd_in();
         opcode = 7'b0100011;
         e = ev(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
         cyc("sw_decode", e, e);
         rnd_in();
         cyc("sw_exec", e, e);
         rnd_in();
         dmem_ready = 1'b0;
         e = ev(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
         cyc("sw_mem", e, e);
         rst = 1'b0;
         rnd_in();
         dmem_ready = 1'b0;
         cyc("sw_rst", 18'h0, 18'h0);
         rst   = 1'b1;
         cnt_a = 0;
         cnt_b = 0;
         run_halt(0);
      end

      do_reset();
      for (int i = 0; i < 30; i++) begin
         int r;
         r = $urandom_range(0, 11);
         if (r == 10) begin
            run_illegal($urandom_range(0, 2));
            do_reset();
         end else if (r == 11) begin
            run_halt($urandom_range(0, 2));
            do_reset();
         end else begin
            run_instr(rand_vec());
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "time limit");
   end

endmodule
